led_sweep_monitor: RTL and testbench
====================================

LED_SWEEP_MONITOR -- requirements
Module: led_sweep_monitor

Interface
REQ-001 Parameter N_LED, default 16: width of the observed LED bus.
REQ-002 Parameter LVL_W, default 5: level width; SHALL satisfy 2**LVL_W > N_LED.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 led_state  input  N_LED  LED bus driven by the flasher; sampled every clk.
REQ-006 err_clr  input  1  synchronous clear of err_sticky.
REQ-007 level  output  LVL_W  registered count of lit LEDs in the last valid pattern.
REQ-008 dir_state  output  2  sweep FSM state: 00 IDLE, 01 RISE, 10 FALL, 11 HOLD.
REQ-009 turn_pulse  output  1  one-cycle pulse on a RISE->FALL turn.
REQ-010 turn_level  output  LVL_W  level at the most recent turn.
REQ-011 sweep_done  output  1  one-cycle pulse when FALL reaches level 0.
REQ-012 pat_err  output  1  one-cycle pulse: sampled pattern not thermometer.
REQ-013 step_err  output  1  one-cycle pulse: level jumped by more than 1.
REQ-014 err_sticky  output  1  set by any pat_err or step_err, held until err_clr.
REQ-015 err_cnt  output  8  error count (see Configuration).

Function
REQ-016 Valid pattern: led_state equals (2**k)-1 for k in 0..N_LED, i.e. contiguous ones from bit 0. k is the decoded level.
REQ-017 All outputs SHALL be registered; each response appears 1 cycle after the sampling edge.
REQ-018 Invalid pattern: pat_err=1; level, dir_state and turn_level hold; no step check that cycle.
REQ-019 Valid pattern, |k - level| > 1: step_err=1; level updates to k; dir_state goes to HOLD, or IDLE if k=0.
REQ-020 Valid pattern, k = level+1: dir_state goes to RISE.
REQ-021 Valid pattern, k = level-1: dir_state goes to FALL. If the previous state was RISE, turn_pulse=1 and turn_level captures the old level.
REQ-022 Valid pattern, k = level: k=0 gives IDLE; otherwise RISE/FALL go to HOLD and HOLD stays HOLD.
REQ-023 A HOLD->FALL transition SHALL NOT pulse turn_pulse.
REQ-024 FALL with k=0 SHALL pulse sweep_done and move to IDLE.
REQ-025 Full boundary: k=N_LED is legal. A following k=N_LED-1 from RISE is a normal turn.
REQ-026 Empty boundary: k=0 from IDLE is legal and stays IDLE.
REQ-027 err_sticky: set has priority over err_clr in the same cycle. err_clr alone clears it the next cycle.
REQ-028 pat_err and step_err are mutually exclusive by construction.

Reset
REQ-029 While rst=1, all outputs SHALL be 0: level=0, dir_state=IDLE, turn_level=0, pulses 0, err_sticky=0, err_cnt=0.
REQ-030 Reset asserted mid-sweep SHALL abort immediately, without sweep_done or turn_pulse.
REQ-031 The first valid sample after reset SHALL be step-checked against level=0.

Configuration
REQ-032 Macro LED_SWEEP_MONITOR_ERRCNT_EN, when defined:
- err_cnt SHALL increment by 1 per cycle with pat_err or step_err.
- err_cnt SHALL saturate at 255.
- err_clr SHALL clear err_cnt, with increment taking priority as in REQ-027.
REQ-033 Macro undefined: err_cnt SHALL be constant 0 and no counter logic is instantiated; all other behaviour is unchanged.

Verification
REQ-034 Reset, then levels 0,1,2,3 on led_state (0x0000,0x0001,0x0003,0x0007) -> level 0..3 one cycle late; dir_state RISE from the second step; no errors.
REQ-035 Rise to 0xFFFF (16), then 0x7FFF -> turn_pulse=1 and turn_level=16 one cycle later; dir_state=FALL.
REQ-036 Continue falling to 0x0000 -> sweep_done=1 for exactly one cycle; dir_state=IDLE; level=0.
REQ-037 Inject 0x0005 mid-sweep -> pat_err=1, err_sticky=1, level holds; with ERRCNT_EN, err_cnt=1.
REQ-038 At level 3, drive 0x003F -> step_err=1, level=6, dir_state=HOLD. Then assert err_clr together with a new error -> err_sticky stays 1.
REQ-039 Assert rst during FALL at level 9 -> all outputs 0 asynchronously, no sweep_done. With ERRCNT_EN, 300 consecutive errors -> err_cnt=255.

Source files
------------

// File: rtl/led_sweep_monitor_if.sv
// Bus between the LED flasher side (master) and the sweep monitor (slave):
// observed LED pattern and error clear in, monitor status out.
interface led_sweep_monitor_if #(
  parameter int unsigned N_LED = 16,
  parameter int unsigned LVL_W = 5
);
  logic [N_LED-1:0] led_state;
  logic             err_clr;
  logic [LVL_W-1:0] level;
  logic [1:0]       dir_state;
  logic             turn_pulse;
  logic [LVL_W-1:0] turn_level;
  logic             sweep_done;
  logic             pat_err;
  logic             step_err;
  logic             err_sticky;
  logic [7:0]       err_cnt;

  modport master (
    output led_state, err_clr,
    input  level, dir_state, turn_pulse, turn_level, sweep_done,
           pat_err, step_err, err_sticky, err_cnt
  );

  modport slave (
    input  led_state, err_clr,
    output level, dir_state, turn_pulse, turn_level, sweep_done,
           pat_err, step_err, err_sticky, err_cnt
  );
endinterface

// File: rtl/led_sweep_monitor.sv
// Watches a thermometer-coded LED bus, tracks the sweep direction and flags
// malformed patterns and level jumps. Optional error counter: LED_SWEEP_MONITOR_ERRCNT_EN.
module led_sweep_monitor #(
  parameter int unsigned N_LED = 16,
  parameter int unsigned LVL_W = 5
) (
  input logic                clk,
  input logic                rst,
  led_sweep_monitor_if.slave bus
);
  localparam int unsigned XW = LVL_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RISE = 2'b01,
    FALL = 2'b10,
    HOLD = 2'b11
  } dir_e;

  dir_e             dir_q, dir_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] turn_level_q, turn_level_d;
  logic             turn_pulse_q, turn_pulse_d;
  logic             sweep_done_q, sweep_done_d;
  logic             pat_err_q, pat_err_d;
  logic             step_err_q, step_err_d;
  logic             err_sticky_q, err_sticky_d;

  logic [LVL_W-1:0] k;
  logic             valid;
  logic [XW-1:0]    k_x, lvl_x;

  // Thermometer check: x & (x+1) is zero only for contiguous ones from bit 0.
  always_comb begin
    valid = ((bus.led_state & (bus.led_state + N_LED'(1))) == '0);
    k = '0;
    for (int unsigned i = 0; i < N_LED; i++) begin
      k = k + LVL_W'(bus.led_state[i]);
    end
    k_x   = {1'b0, k};
    lvl_x = {1'b0, level_q};
  end

  always_comb begin
    dir_d        = dir_q;
    level_d      = level_q;
    turn_level_d = turn_level_q;
    turn_pulse_d = 1'b0;
    sweep_done_d = 1'b0;
    pat_err_d    = 1'b0;
    step_err_d   = 1'b0;

    if (!valid) begin
      pat_err_d = 1'b1;
    end else begin
      level_d = k;
      if (k_x == lvl_x + XW'(1)) begin
        dir_d = RISE;
      end else if (k_x + XW'(1) == lvl_x) begin
        if (dir_q == RISE) begin
          turn_pulse_d = 1'b1;
          turn_level_d = level_q;
        end
        // A fall that lands on zero ends the sweep instead of staying in FALL.
        if (k == '0) begin
          dir_d        = IDLE;
          sweep_done_d = (dir_q == FALL);
        end else begin
          dir_d = FALL;
        end
      end else if (k == level_q) begin
        dir_d = (k == '0) ? IDLE : HOLD;
      end else begin
        step_err_d = 1'b1;
        dir_d      = (k == '0) ? IDLE : HOLD;
      end
    end

    if (pat_err_d || step_err_d) begin
      err_sticky_d = 1'b1;
    end else if (bus.err_clr) begin
      err_sticky_d = 1'b0;
    end else begin
      err_sticky_d = err_sticky_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q        <= IDLE;
      level_q      <= '0;
      turn_level_q <= '0;
      turn_pulse_q <= 1'b0;
      sweep_done_q <= 1'b0;
      pat_err_q    <= 1'b0;
      step_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      dir_q        <= dir_d;
      level_q      <= level_d;
      turn_level_q <= turn_level_d;
      turn_pulse_q <= turn_pulse_d;
      sweep_done_q <= sweep_done_d;
      pat_err_q    <= pat_err_d;
      step_err_q   <= step_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

`ifdef LED_SWEEP_MONITOR_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // A new error wins over err_clr; a saturated counter stays at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (pat_err_d || step_err_d) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 8'd1;
    end else if (bus.err_clr) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = '0;
`endif

  assign bus.level      = level_q;
  assign bus.dir_state  = dir_q;
  assign bus.turn_pulse = turn_pulse_q;
  assign bus.turn_level = turn_level_q;
  assign bus.sweep_done = sweep_done_q;
  assign bus.pat_err    = pat_err_q;
  assign bus.step_err   = step_err_q;
  assign bus.err_sticky = err_sticky_q;
endmodule

// File: tb/tb_led_sweep_monitor.sv
// Scoreboard bench for led_sweep_monitor: directed LED patterns with
// hand-computed responses, checked one cycle later by an independent monitor.
module tb_led_sweep_monitor;
  localparam int unsigned N_LED = 16;
  localparam int unsigned LVL_W = 5;
  localparam int I = 0, R = 1, F = 2, H = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  led_sweep_monitor_if #(.N_LED(N_LED), .LVL_W(LVL_W)) bus ();

  led_sweep_monitor #(.N_LED(N_LED), .LVL_W(LVL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int id;
    int level;
    int dir;
    int tp;
    int tl;
    int sd;
    int pe;
    int se;
    int st;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   vec_id = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ec(input int v);
`ifdef LED_SWEEP_MONITOR_ERRCNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Drive one pattern, queue its expected response, advance past the sampling edge.
  task automatic step(input logic [15:0] led, input logic clr, input int lvl, input int dir,
                      input int tp, input int tl, input int sd, input int pe, input int se,
                      input int st, input int cnt);
    exp_t e;
    bus.led_state = led;
    bus.err_clr   = clr;
    e.id = vec_id; e.level = lvl; e.dir = dir; e.tp = tp; e.tl = tl; e.sd = sd;
    e.pe = pe; e.se = se; e.st = st; e.cnt = ec(cnt);
    q.push_back(e);
    vec_id++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".level"},      int'(bus.level), 0);
    chk({tag, ".dir"},        int'(bus.dir_state), I);
    chk({tag, ".turn_pulse"}, int'(bus.turn_pulse), 0);
    chk({tag, ".turn_level"}, int'(bus.turn_level), 0);
    chk({tag, ".sweep_done"}, int'(bus.sweep_done), 0);
    chk({tag, ".pat_err"},    int'(bus.pat_err), 0);
    chk({tag, ".step_err"},   int'(bus.step_err), 0);
    chk({tag, ".err_sticky"}, int'(bus.err_sticky), 0);
    chk({tag, ".err_cnt"},    int'(bus.err_cnt), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #1;
    rst = 1'b1;
    bus.led_state = 16'h00FF;
    bus.err_clr   = 1'b0;
    #1;
    chk_zero({tag, "_async"});
    @(posedge clk);
    #1;
    chk_zero({tag, "_held"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t  e;
    string p;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        @(negedge clk);
        p = $sformatf("v%0d", e.id);
        chk({p, ".level"},      int'(bus.level),      e.level);
        chk({p, ".dir"},        int'(bus.dir_state),  e.dir);
        chk({p, ".turn_pulse"}, int'(bus.turn_pulse), e.tp);
        chk({p, ".turn_level"}, int'(bus.turn_level), e.tl);
        chk({p, ".sweep_done"}, int'(bus.sweep_done), e.sd);
        chk({p, ".pat_err"},    int'(bus.pat_err),    e.pe);
        chk({p, ".step_err"},   int'(bus.step_err),   e.se);
        chk({p, ".err_sticky"}, int'(bus.err_sticky), e.st);
        chk({p, ".err_cnt"},    int'(bus.err_cnt),    e.cnt);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : driver
    logic [15:0] pat;
    bus.led_state = 16'h00FF;
    bus.err_clr   = 1'b0;
    #2;
    chk_zero("por");
    do_reset("rst0");

    //    led      clr lvl dir tp tl sd pe se st cnt
    step(16'h0000, 0,  0,  I, 0, 0, 0, 0, 0, 0, 0);
    step(16'h0001, 0,  1,  R, 0, 0, 0, 0, 0, 0, 0);
    step(16'h0003, 0,  2,  R, 0, 0, 0, 0, 0, 0, 0);
    step(16'h0007, 0,  3,  R, 0, 0, 0, 0, 0, 0, 0);
    step(16'h003F, 0,  6,  H, 0, 0, 0, 0, 1, 1, 1);
    step(16'h007F, 0,  7,  R, 0, 0, 0, 0, 0, 1, 1);
    step(16'h0005, 1,  7,  R, 0, 0, 0, 1, 0, 1, 2);
    step(16'h00FF, 1,  8,  R, 0, 0, 0, 0, 0, 0, 0);
    step(16'h00FF, 0,  8,  H, 0, 0, 0, 0, 0, 0, 0);
    step(16'h007F, 0,  7,  F, 0, 0, 0, 0, 0, 0, 0);
    step(16'h00FF, 0,  8,  R, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 9; k <= 16; k++) begin
      pat = 16'((32'd1 << k) - 1);
      step(pat, 0, k, R, 0, 0, 0, 0, 0, 0, 0);
    end
    step(16'h7FFF, 0, 15,  F, 1, 16, 0, 0, 0, 0, 0);
    step(16'h0005, 0, 15,  F, 0, 16, 0, 1, 0, 1, 1);
    for (int k = 14; k >= 1; k--) begin
      pat = 16'((32'd1 << k) - 1);
      step(pat, 0, k, F, 0, 16, 0, 0, 0, 1, 1);
    end
    step(16'h0000, 0,  0,  I, 0, 16, 1, 0, 0, 1, 1);
    step(16'h0000, 0,  0,  I, 0, 16, 0, 0, 0, 1, 1);
    step(16'h0000, 1,  0,  I, 0, 16, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      pat = 16'((32'd1 << k) - 1);
      step(pat, 0, k, R, 0, 16, 0, 0, 0, 0, 0);
    end
    step(16'h01FF, 0,  9,  F, 1, 10, 0, 0, 0, 0, 0);

    do_reset("rst_fall");

    step(16'h0007, 0,  3,  H, 0, 0, 0, 0, 1, 1, 1);
    step(16'h0000, 0,  0,  I, 0, 0, 0, 0, 1, 1, 2);
    for (int n = 1; n <= 300; n++) begin
      step(16'h0005, 0, 0, I, 0, 0, 0, 1, 0, 1, (2 + n > 255) ? 255 : 2 + n);
    end
    step(16'h0005, 1,  0,  I, 0, 0, 0, 1, 0, 1, 255);
    step(16'h0000, 1,  0,  I, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
